// File: rtl/packet_fifo.sv
// Store-and-forward packet FIFO: packets become readable only once every flit has arrived in order.
// Optional statistics outputs (drop_cnt, pkt_cnt) are enabled by defining PKT_FIFO_STATS_EN.
module packet_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int FIDX_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    output logic                       wr_ack,
    output logic                       wr_err,
    output logic [$clog2(DEPTH+1)-1:0] capacity,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] pkt_count
`ifdef PKT_FIFO_STATS_EN
    ,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                pkt_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = FIDX_W + 1;

    typedef enum logic {IDLE, RECV} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  stored_q, stored_d;
    logic [CNT_W-1:0]  reserved_q, reserved_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [FIDX_W-1:0] expect_q, expect_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_remain_q, rd_remain_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;

    logic              we;
    logic              commit;
    logic [CNT_W-1:0]  commit_len;
    logic              pop;
    logic              rd_last;

    logic [FIDX_W-1:0] wr_idx;
    logic [LEN_W-1:0]  hdr_len;
    logic [LEN_W-1:0]  rd_hdr_len;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_idx     = wr_data[FIDX_W-1:0];
    assign hdr_len    = LEN_W'(wr_data[2*FIDX_W-1:FIDX_W]) + LEN_W'(1);
    assign rd_hdr_len = LEN_W'(rd_data[2*FIDX_W-1:FIDX_W]) + LEN_W'(1);

    // Slots of the packet still being received are held in reserved_q, not stored_q.
    assign capacity  = CNT_W'(DEPTH) - stored_q - reserved_q;
    assign rd_valid  = (commit_ptr_q != rd_ptr_q) || (stored_q != '0);
    assign rd_data   = mem_q[rd_ptr_q];
    assign pop       = rd_valid && rd_ready;
    assign pkt_count = pkt_count_q;
    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        reserved_d   = reserved_q;
        expect_d     = expect_q;
        len_d        = len_q;
        wr_ack_d     = 1'b0;
        wr_err_d     = 1'b0;
        wr_ready     = 1'b0;
        we           = 1'b0;
        commit       = 1'b0;
        commit_len   = CNT_W'(len_q);

        case (state_q)
            IDLE: begin
                if (wr_idx != '0 || 32'(hdr_len) > DEPTH) begin
                    wr_ready = 1'b1;
                    wr_err_d = wr_valid;
                end else begin
                    wr_ready = 32'(capacity) >= 32'(hdr_len);
                    if (wr_valid && wr_ready) begin
                        we       = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        if (hdr_len == LEN_W'(1)) begin
                            commit       = 1'b1;
                            commit_len   = CNT_W'(1);
                            commit_ptr_d = ptr_inc(wr_ptr_q);
                            wr_ack_d     = 1'b1;
                        end else begin
                            reserved_d = CNT_W'(hdr_len);
                            len_d      = hdr_len;
                            expect_d   = FIDX_W'(1);
                            state_d    = RECV;
                        end
                    end
                end
            end
            RECV: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    if (wr_idx == expect_q) begin
                        we       = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        expect_d = expect_q + FIDX_W'(1);
                        if (LEN_W'(wr_idx) == len_q - LEN_W'(1)) begin
                            commit       = 1'b1;
                            commit_ptr_d = ptr_inc(wr_ptr_q);
                            reserved_d   = '0;
                            wr_ack_d     = 1'b1;
                            state_d      = IDLE;
                        end
                    end else begin
                        // Roll back the partial packet; it never became visible to the reader.
                        wr_ptr_d   = commit_ptr_q;
                        reserved_d = '0;
                        wr_err_d   = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        rd_remain_d = rd_remain_q;
        rd_last     = 1'b0;
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (rd_remain_q == '0) begin
                if (rd_hdr_len == LEN_W'(1)) rd_last = 1'b1;
                else                         rd_remain_d = rd_hdr_len - LEN_W'(1);
            end else begin
                rd_remain_d = rd_remain_q - LEN_W'(1);
                rd_last     = (rd_remain_q == LEN_W'(1));
            end
        end
        stored_d    = stored_q + (commit ? commit_len : '0) - CNT_W'(pop);
        pkt_count_d = pkt_count_q + CNT_W'(commit) - CNT_W'(rd_last);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            stored_q     <= '0;
            reserved_q   <= '0;
            pkt_count_q  <= '0;
            expect_q     <= '0;
            len_q        <= '0;
            rd_remain_q  <= '0;
            wr_ack_q     <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            stored_q     <= stored_d;
            reserved_q   <= reserved_d;
            pkt_count_q  <= pkt_count_d;
            expect_q     <= expect_d;
            len_q        <= len_d;
            rd_remain_q  <= rd_remain_d;
            wr_ack_q     <= wr_ack_d;
            wr_err_q     <= wr_err_d;
        end
    end

    // NOTE: the flit RAM is not reset; pointers and counts alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr_q] <= wr_data;
    end

`ifdef PKT_FIFO_STATS_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (wr_err_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (wr_ack_d && pkt_cnt_q != 16'hFFFF)  pkt_cnt_q  <= pkt_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
`else
    // Statistics counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_packet_fifo.sv
// Self-checking bench for packet_fifo: scoreboard of committed flits compared on every pop.
// A second DEPTH=6 instance covers the oversized-header drop.
module tb_packet_fifo;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        wr_ack;
    logic        wr_err;
    logic [3:0]  capacity;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic [3:0]  pkt_count;

    logic        wr_valid6;
    logic        wr_ready6;
    logic        wr_ack6;
    logic        wr_err6;
    logic [2:0]  capacity6;
    logic        rd_valid6;
    logic [31:0] rd_data6;
    logic        rd_ready6;
    logic [2:0]  pkt_count6;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb [$];

    packet_fifo #(.DATA_W(32), .DEPTH(8), .FIDX_W(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .capacity  (capacity),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .pkt_count (pkt_count)
    );

    packet_fifo #(.DATA_W(32), .DEPTH(6), .FIDX_W(3)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid6),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready6),
        .wr_ack    (wr_ack6),
        .wr_err    (wr_err6),
        .capacity  (capacity6),
        .rd_valid  (rd_valid6),
        .rd_data   (rd_data6),
        .rd_ready  (rd_ready6),
        .pkt_count (pkt_count6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flit(input int len_m1, input int idx);
        logic [25:0] payload;
        payload = 26'($urandom());
        return {payload, 3'(len_m1), 3'(idx)};
    endfunction

    // Present one flit, wait (bounded) for wr_ready, complete the handshake, return the pulses.
    task automatic send(input logic [31:0] d, output logic ack, output logic err);
        int n;
        wr_valid = 1'b1;
        wr_data  = d;
        #1;
        n = 0;
        while (!wr_ready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!wr_ready) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        ack      = wr_ack;
        err      = wr_err;
        wr_valid = 1'b0;
    endtask

    task automatic send6(input logic [31:0] d, output logic err);
        wr_valid6 = 1'b1;
        wr_data   = d;
        #1;
        check("dut6_wr_ready", 32'(wr_ready6), 32'd1);
        @(posedge clk);
        #1;
        err       = wr_err6;
        wr_valid6 = 1'b0;
    endtask

    task automatic send_pkt(input int len, input string tag);
        logic        ack;
        logic        err;
        logic [31:0] d;
        for (int i = 0; i < len; i++) begin
            d = flit(len - 1, i);
            sb.push_back(d);
            send(d, ack, err);
            check({tag, "_ack"}, 32'(ack), 32'(i == len - 1));
            check({tag, "_err"}, 32'(err), 32'd0);
        end
    endtask

    task automatic pop(input string tag);
        logic [31:0] exp;
        rd_ready = 1'b1;
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_rd_data"}, rd_data, exp);
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
    endtask

    initial begin
        logic        ack;
        logic        err;
        logic [31:0] d;

        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        wr_valid6 = 1'b0;
        rd_ready6 = 1'b0;
        repeat (2) tick();
        check("rst_capacity", 32'(capacity), 32'd8);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_capacity6", 32'(capacity6), 32'd6);
        rst_n = 1'b1;
        tick();

        // Test 1: three-flit packet, visible only after commit.
        for (int i = 0; i < 3; i++) begin
            d = flit(2, i);
            sb.push_back(d);
            send(d, ack, err);
            check("t1_ack", 32'(ack), 32'(i == 2));
            check("t1_err", 32'(err), 32'd0);
            check("t1_rd_valid", 32'(rd_valid), 32'(i == 2));
            check("t1_capacity", 32'(capacity), 32'd5);
        end
        check("t1_pkt_count", 32'(pkt_count), 32'd1);
        tick();
        check("t1_ack_one_cycle", 32'(wr_ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            pop("t1_pop");
            check("t1_pkt_count_pop", 32'(pkt_count), 32'(i == 2 ? 0 : 1));
        end
        check("t1_capacity_end", 32'(capacity), 32'd8);
        check("t1_rd_valid_end", 32'(rd_valid), 32'd0);

        // Test 2: out-of-sequence flit rolls back the partial packet.
        send(flit(2, 0), ack, err);
        check("t2_hdr_err", 32'(err), 32'd0);
        send(flit(2, 1), ack, err);
        check("t2_f1_err", 32'(err), 32'd0);
        send(flit(2, 1), ack, err);
        check("t2_seq_err", 32'(err), 32'd1);
        check("t2_seq_ack", 32'(ack), 32'd0);
        check("t2_capacity", 32'(capacity), 32'd8);
        check("t2_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        check("t2_err_one_cycle", 32'(wr_err), 32'd0);

        // Test 3: fill, stall a header, free space, accept across the wrap.
        send_pkt(4, "t3_a");
        send_pkt(4, "t3_b");
        check("t3_full_capacity", 32'(capacity), 32'd0);
        check("t3_full_pkts", 32'(pkt_count), 32'd2);
        d = flit(1, 0);
        wr_valid = 1'b1;
        wr_data  = d;
        #1;
        check("t3_stall_ready", 32'(wr_ready), 32'd0);
        tick();
        check("t3_stall_ready2", 32'(wr_ready), 32'd0);
        check("t3_stall_no_err", 32'(wr_err), 32'd0);
        pop("t3_pop1");
        check("t3_ready_after1", 32'(wr_ready), 32'd0);
        pop("t3_pop2");
        check("t3_ready_after2", 32'(wr_ready), 32'd1);
        sb.push_back(d);
        send(d, ack, err);
        check("t3_c_hdr_ack", 32'(ack), 32'd0);
        check("t3_c_hdr_err", 32'(err), 32'd0);
        d = flit(1, 1);
        sb.push_back(d);
        send(d, ack, err);
        check("t3_c_ack", 32'(ack), 32'd1);
        check("t3_pkt_count", 32'(pkt_count), 32'd3);
        for (int i = 0; i < 8; i++) pop("t3_drain");
        check("t3_pkt_count_end", 32'(pkt_count), 32'd0);
        check("t3_capacity_end", 32'(capacity), 32'd8);

        // Test 4: commit of one packet coincides with the pop of another's last flit.
        send_pkt(2, "t4_p");
        pop("t4_p0");
        check("t4_pkt_count_pre", 32'(pkt_count), 32'd1);
        send(flit(1, 0), ack, err);
        sb.push_back(wr_data);
        d = flit(1, 1);
        sb.push_back(d);
        wr_valid = 1'b1;
        wr_data  = d;
        rd_ready = 1'b1;
        #1;
        check("t4_rd_valid", 32'(rd_valid), 32'd1);
        check("t4_rd_data", rd_data, sb.pop_front());
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("t4_ack", 32'(wr_ack), 32'd1);
        check("t4_pkt_count", 32'(pkt_count), 32'd1);
        check("t4_capacity", 32'(capacity), 32'd6);
        pop("t4_q0");
        pop("t4_q1");
        check("t4_pkt_count_end", 32'(pkt_count), 32'd0);

        // Test 5: oversized header on DEPTH=6, stray non-header flit in IDLE.
        send6(flit(7, 0), err);
        check("t5_big_err", 32'(err), 32'd1);
        check("t5_big_capacity", 32'(capacity6), 32'd6);
        check("t5_big_rd_valid", 32'(rd_valid6), 32'd0);
        check("t5_big_pkts", 32'(pkt_count6), 32'd0);
        send(flit(2, 3), ack, err);
        check("t5_stray_err", 32'(err), 32'd1);
        check("t5_stray_ack", 32'(ack), 32'd0);
        check("t5_stray_capacity", 32'(capacity), 32'd8);

        // Test 6: single-flit packet commits at once, then reset mid-packet.
        send_pkt(1, "t6_single");
        check("t6_pkt_count", 32'(pkt_count), 32'd1);
        send(flit(2, 0), ack, err);
        send(flit(2, 1), ack, err);
        check("t6_partial_capacity", 32'(capacity), 32'd4);
        rst_n = 1'b0;
        tick();
        check("t6_rst_capacity", 32'(capacity), 32'd8);
        check("t6_rst_pkt_count", 32'(pkt_count), 32'd0);
        check("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("t6_rst_wr_ack", 32'(wr_ack), 32'd0);
        check("t6_rst_wr_err", 32'(wr_err), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        tick();
        send_pkt(2, "t6_after");
        pop("t6_after0");
        pop("t6_after1");
        check("t6_end_pkt_count", 32'(pkt_count), 32'd0);
        check("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
